spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 39 +++
 rtl/spi_tx_shifter.sv | 62 ++++++
 rtl/spi_slave.sv | 140 ++++++++++++++
 tb/tb_spi_slave.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave: default frame/data widths, the FSM
// state encoding, the 2-bit command codes carried in frame bits [9:8], and
// the routing helper used when the first frame bit arrives.
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int FRAME_W_DEF = 10;
    localparam int DATA_W_DEF  = 8;

    // FSM state encoding
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHK_CMD   = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] READ_ADD  = 3'd3;
    localparam logic [2:0] READ_DATA = 3'd4;

    // Command codes (frame bits [9:8])
    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    // A leading 0 is always a write. A leading 1 is a read; whether it is the
    // address or the data half depends on whether a read address has already
    // been accepted.
    function automatic logic [2:0] route_cmd(input logic cmd_msb,
                                             input logic addr_seen);
        if (!cmd_msb) begin
            return WRITE;
        end else if (addr_seen) begin
            return READ_DATA;
        end else begin
            return READ_ADD;
        end
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// ---------------------------------------------------------------------------
// spi_tx_shifter
// Parallel-load, MSB-first serial output shifter driving MISO.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   clear       - synchronous clear of the shifter (frame abort/end)
//   load        - capture data_in; its MSB appears on serial_out next cycle
//   data_in     - parallel read data
//   serial_out  - serial data, 0 whenever the shifter is not active
//   busy        - bits are still being shifted out
//   done        - all bits have been sent; held until clear or a new load
// ---------------------------------------------------------------------------
module spi_tx_shifter
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic              serial_out,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;

    // cnt_q holds the number of bits still to present; the bit on
    // serial_out is always the current MSB of shift_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (load) begin
            shift_q <= data_in;
            cnt_q   <= CNT_W'(DATA_W);
            done_q  <= 1'b0;
        end else if (cnt_q != '0) begin
            shift_q <= {shift_q[DATA_W-2:0], 1'b0};
            cnt_q   <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                done_q <= 1'b1;
            end
        end
    end

    assign busy       = (cnt_q != '0);
    assign serial_out = busy & shift_q[DATA_W-1];
    assign done       = done_q;

endmodule

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// SPI slave front end for a small memory: receives 10-bit frames (2-bit
// command + 8-bit address/data) MSB first on MOSI, forwards each complete
// frame on rx_data with a one-cycle rx_valid pulse, and returns read data
// MSB first on MISO after a read-data frame.
// Ports:
//   clk, rst_n - clock (rising edge) and asynchronous active-low reset
//   SS_n       - slave select, active low; high aborts or ends a frame
//   MOSI       - serial data from the master
//   MISO       - serial read data to the master, 0 when not shifting
//   rx_data    - last complete frame ([9:8] command, [7:0] addr/data)
//   rx_valid   - one-cycle pulse marking a new rx_data
//   tx_data    - read data from the memory
//   tx_valid   - tx_data valid, only looked at in READ_DATA
// ---------------------------------------------------------------------------
module spi_slave
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    // bit_cnt walks 0..LAST_BIT over the bits after the command MSB and then
    // parks at FRAME_DONE until SS_n rises.
    localparam logic [3:0] LAST_BIT   = 4'(FRAME_W - 2);
    localparam logic [3:0] FRAME_DONE = 4'(FRAME_W - 1);

    logic [2:0]         state;
    logic [3:0]         bit_cnt;
    logic [FRAME_W-2:0] rx_shift;
    logic               rd_addr_seen;
    logic               ss_armed;

    logic [FRAME_W-1:0] frame_next;
    logic [1:0]         frame_cmd;
    logic               in_body;
    logic               tx_load;
    logic               tx_clear;
    logic               tx_busy;
    logic               tx_done;

    assign frame_next = {rx_shift, MOSI};
    assign frame_cmd  = frame_next[FRAME_W-1 -: 2];
    assign in_body    = (state == WRITE) || (state == READ_ADD) ||
                        (state == READ_DATA);

    // Read data is accepted once per read-data frame, only after the frame
    // itself has completed and only while nothing has been shifted yet.
    assign tx_load  = (state == READ_DATA) && (bit_cnt == FRAME_DONE) &&
                      !SS_n && tx_valid && !tx_busy && !tx_done;
    assign tx_clear = SS_n && (state != IDLE);

    // ss_armed stays low after reset until SS_n is seen high, so a reset
    // released in the middle of a frame cannot restart on its leftover bits.
    // SS_n high always takes priority, including on the edge of the last
    // bit, so an abort never produces rx_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
            ss_armed     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n) begin
                ss_armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!SS_n && ss_armed) begin
                        state   <= CHK_CMD;
                        bit_cnt <= '0;
                    end
                end
                CHK_CMD: begin
                    if (SS_n) begin
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                    end else begin
                        rx_shift <= frame_next[FRAME_W-2:0];
                        bit_cnt  <= '0;
                        state    <= route_cmd(MOSI, rd_addr_seen);
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (SS_n) begin
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                    end else if (bit_cnt != FRAME_DONE) begin
                        rx_shift <= frame_next[FRAME_W-2:0];
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            rx_data  <= frame_next;
                            rx_valid <= 1'b1;
                            if (frame_cmd == RD_ADDR) begin
                                rd_addr_seen <= 1'b1;
                            end else if (frame_cmd == RD_DATA) begin
                                rd_addr_seen <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    spi_tx_shifter #(
        .DATA_W (DATA_W)
    ) u_tx_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (tx_clear),
        .load       (tx_load),
        .data_in    (tx_data),
        .serial_out (MISO),
        .busy       (tx_busy),
        .done       (tx_done)
    );

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
// Directed self-checking bench for spi_slave. Inputs change on the falling
// edge and outputs are observed on the falling edge. Expected frames and
// MISO bits are queued as stimulus is driven and popped as the DUT responds.
// ---------------------------------------------------------------------------
module tb_spi_slave;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] exp_q[$];
    logic       miso_q[$];

    always #5 clk = ~clk;

    spi_slave #(
        .FRAME_W (10),
        .DATA_W  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic ss, input logic mosi,
                                  input logic txv, input logic [7:0] txd);
        @(negedge clk);
        SS_n     = ss;
        MOSI     = mosi;
        tx_valid = txv;
        tx_data  = txd;
    endtask

    // Selects the slave and shifts nbits of the frame MSB first; a full frame
    // queues its expected rx_data, a short one is left as an abort.
    task automatic send_frame(input logic [9:0] frame, input int nbits,
                              input logic [2:0] route);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < nbits; i++) begin
            apply_stimulus(1'b0, frame[9-i], 1'b0, 8'h00);
            if (i == 1) check_output("route", {29'b0, dut.state}, {29'b0, route});
            check_output("miso_quiet", {31'b0, MISO}, 32'h0);
        end
        if (nbits == 10) exp_q.push_back(frame);
    endtask

    task automatic end_frame();
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        check_output("rx_pending", exp_q.size(), 32'h0);
    endtask

    task automatic read_data(input logic [7:0] d, input int nbits);
        apply_stimulus(1'b0, 1'b0, 1'b1, d);
        for (int b = 7; b >= 0; b--) miso_q.push_back(d[b]);
        for (int i = 0; i < nbits; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
            check_output("miso_bit", {31'b0, MISO}, {31'b0, miso_q.pop_front()});
        end
    endtask

    // Every rx_valid pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("rx_unexpected_pulse", {31'b0, rx_valid}, 32'h0);
            end else begin
                check_output("rx_data", {22'b0, rx_data}, {22'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #2;
        check_output("reset_rx_data", {22'b0, rx_data}, 32'h0);
        check_output("reset_rx_valid", {31'b0, rx_valid}, 32'h0);
        check_output("reset_miso", {31'b0, MISO}, 32'h0);
        check_output("reset_state", {29'b0, dut.state}, {29'b0, IDLE});
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);

        $display("[TB] write address and write data frames");
        send_frame(10'h03C, 10, WRITE);
        end_frame();
        check_output("flag_after_wr_addr", {31'b0, dut.rd_addr_seen}, 32'h0);
        send_frame(10'h1A5, 10, WRITE);
        end_frame();
        check_output("flag_after_wr_data", {31'b0, dut.rd_addr_seen}, 32'h0);

        $display("[TB] read address then read data");
        send_frame(10'h23C, 10, READ_ADD);
        end_frame();
        check_output("flag_after_rd_addr", {31'b0, dut.rd_addr_seen}, 32'h1);
        send_frame(10'h300, 10, READ_DATA);
        read_data(8'hA5, 8);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, 8'h3C);
            check_output("miso_after_read", {31'b0, MISO}, 32'h0);
        end
        check_output("state_hold_read", {29'b0, dut.state}, {29'b0, READ_DATA});
        end_frame();
        check_output("flag_after_rd_data", {31'b0, dut.rd_addr_seen}, 32'h0);

        $display("[TB] abort after five bits");
        send_frame(10'h055, 5, WRITE);
        end_frame();
        check_output("abort_rx_data", {22'b0, rx_data}, 32'h300);
        check_output("abort_state", {29'b0, dut.state}, {29'b0, IDLE});
        send_frame(10'h055, 10, WRITE);
        end_frame();

        $display("[TB] async reset during MISO shift");
        send_frame(10'h23C, 10, READ_ADD);
        end_frame();
        send_frame(10'h3C4, 10, READ_DATA);
        read_data(8'h5A, 3);
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_mid_miso", {31'b0, MISO}, 32'h0);
        check_output("rst_mid_state", {29'b0, dut.state}, {29'b0, IDLE});
        check_output("rst_mid_rx_data", {22'b0, rx_data}, 32'h0);
        check_output("rst_mid_flag", {31'b0, dut.rd_addr_seen}, 32'h0);
        miso_q.delete();
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, i[0], 1'b0, 8'h00);
            check_output("rst_release_idle", {29'b0, dut.state}, {29'b0, IDLE});
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        send_frame(10'h377, 10, READ_ADD);
        end_frame();

        $display("[TB] SS_n rises on the last bit");
        send_frame(10'h0F0, 9, WRITE);
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        check_output("late_abort_valid", {31'b0, rx_valid}, 32'h0);
        check_output("late_abort_rx_data", {22'b0, rx_data}, 32'h377);
        check_output("late_abort_state", {29'b0, dut.state}, {29'b0, IDLE});

        $display("[TB] back-to-back read address frames");
        send_frame(10'h201, 10, READ_ADD);
        end_frame();
        check_output("flag_b2b_first", {31'b0, dut.rd_addr_seen}, 32'h1);
        send_frame(10'h202, 10, READ_DATA);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        check_output("b2b_miso_idle", {31'b0, MISO}, 32'h0);
        end_frame();
        check_output("flag_b2b_second", {31'b0, dut.rd_addr_seen}, 32'h1);
        check_output("final_rx_data", {22'b0, rx_data}, 32'h202);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
